// File: rtl/mem_pkg.sv
// mem_pkg: shared funct3 codes, FSM encoding and load-lane formatting for the data memory responder.
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    return (f3 == F3_B)  ? {{24{sh[7]}}, sh[7:0]} :
           (f3 == F3_BU) ? {24'h0, sh[7:0]} :
           (f3 == F3_H)  ? {{16{sh[15]}}, sh[15:0]} :
           (f3 == F3_HU) ? {16'h0, sh[15:0]} : word;
  endfunction
endpackage

// File: rtl/data_mem_bram.sv
// data_mem_bram: single-port word RAM with byte-enable writes and registered read.
module data_mem_bram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: one-at-a-time load/store responder with error checking,
// byte-lane formatting and programmable wait states in front of a block RAM.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        err, fire;
  logic [3:0]  be;
  logic [31:0] wrep, ram_rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
    end
  end
  // Counter starts at WAIT_CYCLES+1 so the RAM edge lands 2+WAIT_CYCLES edges after accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_ACCESS;
        cnt_d   = 5'(WAIT_CYCLES) + 5'd1;
        we_d    = req_we;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        f3_d    = req_funct3;
      end
      S_ACCESS: if (cnt_q == '0) state_d = S_RESP; else cnt_d = cnt_q - 5'd1;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    err  = (((f3_q == F3_H) || (f3_q == F3_HU)) && addr_q[0])
        || ((f3_q == F3_W) && (addr_q[1:0] != 2'b00))
        || (|addr_q[31:AW+2])
        || (f3_q inside {3'b011, 3'b110, 3'b111})
        || (we_q && ((f3_q == F3_BU) || (f3_q == F3_HU)));
    fire = (state_q == S_ACCESS) && (cnt_q == '0);
    be   = (f3_q[1:0] == 2'b10) ? 4'hF : f3_q[0] ? (addr_q[1] ? 4'hC : 4'h3) : 4'b0001 << addr_q[1:0];
    wrep = (f3_q[1:0] == 2'b10) ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  end
  data_mem_bram #(.DEPTH_WORDS(DEPTH_WORDS)) u_bram (
    .clk   (clk),
    .en    (fire),
    .we    (we_q && !err),
    .be    (be),
    .addr  (addr_q[AW+1:2]),
    .wdata (wrep),
    .rdata (ram_rdata)
  );
  // RAM output only moves on fire, so the formatted response stays stable through RESP.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_err   = rsp_valid && err;
    rsp_rdata = (rsp_valid && !err && !we_q) ? lane_extract(ram_rdata, addr_q[1:0], f3_q) : '0;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table-driven scoreboard bench for two responders (0 and 3 wait states).
module tb_data_mem_responder;
  import mem_pkg::*;
  typedef struct {logic [31:0] rd; logic er;} exp_t;
  typedef struct {bit we; logic [31:0] a; logic [2:0] f; logic [31:0] wd; logic [31:0] rd; bit er;} vec_t;
  logic        clk = 1'b0, rst = 1'b0, rsp_ready = 1'b0;
  logic        req_valid [2], req_ready [2], req_we [2], rsp_valid [2], rsp_err [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  logic [2:0]  req_funct3 [2];
  int          wt [2] = '{0, 3};
  int          n_vec = 0, n_bad = 0;
  exp_t        sb [$];
  vec_t        tbl [$];
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_funct3(req_funct3[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_funct3(req_funct3[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic check_reset(input int s);
    chk("rst_req_ready", 32'(req_ready[s]), 1);
    chk("rst_rsp_valid", 32'(rsp_valid[s]), 0);
    chk("rst_rsp_rdata", rsp_rdata[s], 0);
    chk("rst_rsp_err", 32'(rsp_err[s]), 0);
  endtask
  task automatic drive(input int s, input bit we, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd);
    req_we[s] = we; req_addr[s] = a; req_funct3[s] = f; req_wdata[s] = wd; req_valid[s] = 1'b1;
  endtask
  task automatic xact(input int s, input bit we, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] wd, input logic [31:0] er, input bit ee, input int hold);
    int lat;
    exp_t e;
    logic [31:0] held;
    sb.push_back('{er, ee});
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[s]), 1);
    drive(s, we, a, f, wd);
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0;
    while (!rsp_valid[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(2 + wt[s]));
    e = sb.pop_front();
    chk("rsp_rdata", rsp_rdata[s], e.rd);
    chk("rsp_err", 32'(rsp_err[s]), 32'(e.er));
    held = rsp_rdata[s];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drive(s, 1'b1, 32'h10, F3_W, 32'h0BADBAD0);
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[s]), 1);
      chk("hold_rdata", rsp_rdata[s], held);
      chk("hold_ready", 32'(req_ready[s]), 0);
    end
    @(negedge clk);
    req_valid[s] = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_cleared", 32'(rsp_valid[s]), 0);
    chk("ready_back", 32'(req_ready[s]), 1);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_funct3[i] = '0; req_wdata[i] = '0;
    end
    tbl.push_back('{1, 32'h10,  F3_W,   32'hDEADBEEF, 32'h0,        0});
    tbl.push_back('{0, 32'h10,  F3_W,   32'h0,        32'hDEADBEEF, 0});
    tbl.push_back('{0, 32'h13,  F3_B,   32'h0,        32'hFFFFFFDE, 0});
    tbl.push_back('{0, 32'h13,  F3_BU,  32'h0,        32'h000000DE, 0});
    tbl.push_back('{0, 32'h12,  F3_H,   32'h0,        32'hFFFFDEAD, 0});
    tbl.push_back('{0, 32'h10,  F3_HU,  32'h0,        32'h0000BEEF, 0});
    tbl.push_back('{1, 32'h11,  F3_B,   32'h00000055, 32'h0,        0});
    tbl.push_back('{0, 32'h10,  F3_W,   32'h0,        32'hDEAD55EF, 0});
    tbl.push_back('{0, 32'h12,  F3_W,   32'h0,        32'h0,        1});
    tbl.push_back('{1, 32'h13,  F3_H,   32'h0000FFFF, 32'h0,        1});
    tbl.push_back('{0, 32'h1000, F3_W,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 32'h10,  3'b011, 32'h0,        32'h0,        1});
    tbl.push_back('{1, 32'h10,  F3_BU,  32'h0,        32'h0,        1});
    tbl.push_back('{0, 32'h10,  F3_W,   32'h0,        32'hDEAD55EF, 0});
    tbl.push_back('{1, 32'h0,   F3_W,   32'h0,        32'h0,        0});
    tbl.push_back('{1, 32'h2,   F3_H,   32'hAAAA1234, 32'h0,        0});
    tbl.push_back('{0, 32'h0,   F3_W,   32'h0,        32'h12340000, 0});
    tbl.push_back('{0, 32'h3,   F3_B,   32'h0,        32'h00000012, 0});
    tbl.push_back('{0, 32'h2,   F3_H,   32'h0,        32'h00001234, 0});
    tbl.push_back('{1, 32'h0,   F3_B,   32'hFFFFFF80, 32'h0,        0});
    tbl.push_back('{0, 32'h0,   F3_B,   32'h0,        32'hFFFFFF80, 0});
    tbl.push_back('{0, 32'h0,   F3_BU,  32'h0,        32'h00000080, 0});
    tbl.push_back('{1, 32'hFFC, F3_W,   32'h80000001, 32'h0,        0});
    tbl.push_back('{0, 32'hFFC, F3_W,   32'h0,        32'h80000001, 0});
    tbl.push_back('{0, 32'hFFE, F3_HU,  32'h0,        32'h00008000, 0});
    tbl.push_back('{0, 32'hFFE, F3_H,   32'h0,        32'hFFFF8000, 0});
    repeat (3) @(posedge clk);
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) xact(0, tbl[i].we, tbl[i].a, tbl[i].f, tbl[i].wd, tbl[i].rd, tbl[i].er, 0);
    // Stalled response: a store offered during the stall must be ignored.
    xact(0, 1'b0, 32'h10, F3_W, 32'h0, 32'hDEAD55EF, 1'b0, 5);
    xact(0, 1'b0, 32'h10, F3_W, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    xact(1, 1'b1, 32'h20, F3_W, 32'h11111111, 32'h0, 1'b0, 0);
    xact(1, 1'b0, 32'h20, F3_W, 32'h0, 32'h11111111, 1'b0, 0);
    // Reset in the middle of a waited store must abort it.
    @(negedge clk);
    drive(1, 1'b1, 32'h20, F3_W, 32'h22222222);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("access_busy", 32'(req_ready[1]), 0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b0;
    #1;
    check_reset(1);
    @(negedge clk);
    rst = 1'b1;
    xact(1, 1'b0, 32'h20, F3_W, 32'h0, 32'h11111111, 1'b0, 0);
    xact(0, 1'b0, 32'h10, F3_W, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
